// File: rtl/dino_pkg.sv
// Shared encodings and default geometry for the dino game sequencer.
package dino_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] JUMP = 2'd2;
    localparam logic [1:0] DEAD = 2'd3;

    localparam int GROUND_DEF       = 335;
    localparam int DINO_X_DEF       = 50;
    localparam int DINO_W_DEF       = 60;
    localparam int DINO_H_DEF       = 60;
    localparam int CACTUS_W_DEF     = 49;
    localparam int CACTUS_H_DEF     = 80;
    localparam int CACTUS_START_DEF = 550;
    localparam int CACTUS_MIN_DEF   = 20;

    localparam int POS_W = 12;
    localparam int VEL_W = 8;

    typedef logic signed [VEL_W-1:0] vel_t;

endpackage

// File: rtl/dino_game_ctrl_frame_tick_sync.sv
// Two-flop synchroniser followed by a rising-edge detector (1-clk pulse).
module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic [2:0] sh_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= {sh_q[1:0], d_i};
        end
    end

    assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/dino_game_ctrl.sv
// Per-frame dino game sequencer: jump physics, cactus scroll, collision, FSM.
// Define DINO_SPEEDUP_EN to raise cactus speed every 8 points up to MAX_SPEED.
module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter int GROUND       = GROUND_DEF,
    parameter int DINO_X       = DINO_X_DEF,
    parameter int DINO_W       = DINO_W_DEF,
    parameter int DINO_H       = DINO_H_DEF,
    parameter int CACTUS_W     = CACTUS_W_DEF,
    parameter int CACTUS_H     = CACTUS_H_DEF,
    parameter int CACTUS_START = CACTUS_START_DEF,
    parameter int CACTUS_MIN   = CACTUS_MIN_DEF,
    parameter int SPEED        = 1,
    parameter int JUMP_V0      = 13,
    parameter int GRAVITY      = 1
`ifdef DINO_SPEEDUP_EN
    ,
    parameter int MAX_SPEED    = 8
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screen_end,
    input  logic        up,
    input  logic        down,
    output logic [31:0] dino_x,
    output logic [31:0] dino_y,
    output logic [31:0] cacti_x,
    output logic [31:0] cacti_y,
    output logic        game_over,
    output logic [15:0] score,
    output logic [1:0]  state
);

    localparam int REST = GROUND - DINO_H;
    localparam int CY   = GROUND - CACTUS_H;

    localparam logic [POS_W-1:0]        REST_P  = POS_W'(REST);
    localparam logic signed [POS_W-1:0] REST_S  = POS_W'(REST);
    localparam logic [POS_W-1:0]        START_P = POS_W'(CACTUS_START);
    localparam logic [POS_W-1:0]        MIN_P   = POS_W'(CACTUS_MIN);

    localparam vel_t V0 = vel_t'(JUMP_V0);
    localparam vel_t G1 = vel_t'(GRAVITY);
    localparam vel_t G2 = vel_t'(2 * GRAVITY);

    logic tick;
    logic up_rise;

    frame_tick_sync u_frame (
        .clk    (clk),
        .rst_n  (reset),
        .d_i    (screen_end),
        .rise_o (tick)
    );

    frame_tick_sync u_up (
        .clk    (clk),
        .rst_n  (reset),
        .d_i    (up),
        .rise_o (up_rise)
    );

    logic [1:0]              state_q, state_d;
    logic [POS_W-1:0]        y_q, y_d;
    logic [POS_W-1:0]        cx_q, cx_d;
    logic [15:0]             score_q, score_d;
    vel_t                    vel_q, vel_d;
    logic                    pend_q, pend_d;

    logic [POS_W-1:0]        step;
    logic                    reload;
    logic [POS_W-1:0]        cx_mv;
    logic [15:0]             score_inc;
    logic signed [POS_W-1:0] ny;
    logic [POS_W-1:0]        y_clamp;
    logic                    land;
    logic [POS_W-1:0]        y_new;
    logic                    hit;

`ifdef DINO_SPEEDUP_EN
    logic [7:0] speed_q, speed_d;
    assign step = POS_W'(speed_q);
`else
    assign step = POS_W'(SPEED);
`endif

    assign reload    = cx_q < MIN_P;
    assign cx_mv     = reload ? START_P : cx_q - step;
    assign score_inc = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;

    // Signed arithmetic so a high jump clamps at the top instead of wrapping.
    assign ny      = $signed(y_q) - POS_W'(vel_q);
    assign y_clamp = ny[POS_W-1] ? '0 : ny;
    assign land    = ny >= REST_S;
    assign y_new   = (state_q == JUMP) ? (land ? REST_P : y_clamp) : y_q;

    assign hit = (DINO_X < int'(cx_mv) + CACTUS_W)
              && (int'(cx_mv) < DINO_X + DINO_W)
              && (int'(y_new) < CY + CACTUS_H)
              && (CY < int'(y_new) + DINO_H);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cx_d    = cx_q;
        score_d = score_q;
        vel_d   = vel_q;
        pend_d  = up_rise | (pend_q & ~tick);
`ifdef DINO_SPEEDUP_EN
        speed_d = speed_q;
`endif
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (pend_q) state_d = RUN;
                end
                RUN, JUMP: begin
                    cx_d = cx_mv;
                    y_d  = y_new;
                    if (reload) begin
                        score_d = score_inc;
`ifdef DINO_SPEEDUP_EN
                        if (score_inc[2:0] == 3'd0 && speed_q < 8'(MAX_SPEED))
                            speed_d = speed_q + 8'd1;
`endif
                    end
                    if (state_q == RUN) begin
                        if (pend_q) begin
                            state_d = JUMP;
                            vel_d   = V0;
                        end
                    end else if (land) begin
                        state_d = RUN;
                        vel_d   = '0;
                    end else begin
                        vel_d = vel_q - (down ? G2 : G1);
                    end
                    // A landing that also overlaps still ends the game.
                    if (hit) state_d = DEAD;
                end
                DEAD: begin
                    if (pend_q) begin
                        state_d = RUN;
                        y_d     = REST_P;
                        cx_d    = START_P;
                        score_d = '0;
                        vel_d   = '0;
`ifdef DINO_SPEEDUP_EN
                        speed_d = 8'(SPEED);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            y_q     <= REST_P;
            cx_q    <= START_P;
            score_q <= '0;
            vel_q   <= '0;
            pend_q  <= 1'b0;
`ifdef DINO_SPEEDUP_EN
            speed_q <= 8'(SPEED);
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cx_q    <= cx_d;
            score_q <= score_d;
            vel_q   <= vel_d;
            pend_q  <= pend_d;
`ifdef DINO_SPEEDUP_EN
            speed_q <= speed_d;
`endif
        end
    end

    assign dino_x    = 32'(DINO_X);
    assign dino_y    = 32'(y_q);
    assign cacti_x   = 32'(cx_q);
    assign cacti_y   = 32'(CY);
    assign score     = score_q;
    assign state     = state_q;
    assign game_over = (state_q == DEAD);

endmodule
